mole_hit_detect: RTL

//  Player-side end of the mole interface. Conditions 8 raw hole buttons and

---
 rtl/mole_hit_detect_pkg.sv | 21 ++
 rtl/mole_hit_detect_btn_debounce.sv | 33 +++
 rtl/mole_hit_detect.sv | 46 ++++
 3 files changed

// File: rtl/mole_hit_detect_pkg.sv
// mole_hit_detect_pkg: shared sizes, types and arithmetic helpers for the mole hit detector
package mole_hit_detect_pkg;
  localparam int N_MOLES = 8;
  localparam int DEBOUNCE_CYC_DEF = 1_000_000;
  localparam int SCORE_W = 8;
  localparam int PC_W = $clog2(N_MOLES + 1);
  typedef logic [N_MOLES-1:0] mole_vec_t;
  typedef logic [SCORE_W-1:0] score_t;
  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction
  function automatic logic [PC_W-1:0] popcount(input mole_vec_t v);
    popcount = '0;
    for (int i = 0; i < N_MOLES; i++) popcount = popcount + PC_W'(v[i]);
  endfunction
  function automatic score_t sat_add(input score_t a, input logic [PC_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W + 1)'(b);
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction
endpackage

// File: rtl/mole_hit_detect_btn_debounce.sv
// btn_debounce: synchronise one raw button, debounce it and emit a one-cycle press strobe
module btn_debounce import mole_hit_detect_pkg::*; #(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CNT_W = cnt_w(DEBOUNCE_CYC);
  logic s1, s2, level, level_q;
  logic [CNT_W-1:0] cnt;
  // counter runs only while the synced value disagrees with the accepted level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      level_q <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      level_q <= level;
      if (s2 == level) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYC)) begin
        level <= s2;
        cnt <= '0;
      end else cnt <= cnt + CNT_W'(1);
    end
  end
  assign press = level & ~level_q;
endmodule

// File: rtl/mole_hit_detect.sv
// mole_hit_detect: classify debounced hole presses against raised moles, drive molehit and keep scores
module mole_hit_detect import mole_hit_detect_pkg::*; #(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_MOLES-1:0] btn,
  input  logic [N_MOLES-1:0] omole,
  output logic [N_MOLES-1:0] molehit,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses
);
  mole_vec_t press, gated, hits, empties;
  for (genvar i = 0; i < N_MOLES; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk(CLK100MHZ),
      .rst(reset),
      .raw(btn[i]),
      .press(press[i])
    );
  end
  // a press on a hole already flagged is neither a hit nor a miss
  always_comb begin
    gated = press & {N_MOLES{enable}};
    hits = gated & omole & ~molehit;
    empties = gated & ~omole;
  end
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      molehit <= '0;
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      score <= '0;
      misses <= '0;
    end else begin
      molehit <= enable ? ((molehit & omole) | hits) : '0;
      hit_pulse <= |hits;
      miss_pulse <= |empties;
      score <= sat_add(score, popcount(hits));
      misses <= sat_add(misses, popcount(empties));
    end
  end
endmodule
